// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: pairs each issued fetch address with the ROM read data
// one cycle later and buffers {pc, inst, prediction, adel} for ID; flush/redirect kills all.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     redirect,
    input  logic [31:0]              if_pc,
    input  logic                     if_pre_taken,
    input  logic [31:0]              if_pre_addr,
    input  logic                     rom_en,
    input  logic [31:0]              rom_rdata,
    output logic                     stall_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic [31:0]              id_pre_addr,
    output logic                     id_pre_taken,
    output logic                     id_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pre_addr;
        logic        pre_taken;
        logic        adel;
    } tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pre_addr;
        logic        pre_taken;
        logic        adel;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           infl_v_q, infl_v_d;
    tag_t           infl_q, infl_d;

    logic           kill;
    logic           issue;
    logic           push;
    logic           pop;
    logic [AW+1:0]  occupancy;
    entry_t         head;
    entry_t         wr_entry;

    assign kill  = flush | redirect;
    assign count = wr_ptr_q - rd_ptr_q;

    // The in-flight fetch reserves a slot so a push can never land on a full queue.
    assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, infl_v_q};
    assign stall_pc  = (occupancy >= DEPTH_W);

    assign issue = rom_en & ~stall_pc & ~kill & ~rst;
    assign push  = infl_v_q & ~kill & ~rst;
    assign pop   = id_valid & id_ready & ~kill;

    always_comb begin
        infl_d   = infl_q;
        infl_v_d = issue;
        if (issue) begin
            infl_d.pc        = if_pc;
            infl_d.pre_addr  = if_pre_addr;
            infl_d.pre_taken = if_pre_taken;
            infl_d.adel      = (if_pc[1:0] != 2'b00);
        end
    end

    always_comb begin
        wr_entry.pc        = infl_q.pc;
        wr_entry.inst      = infl_q.adel ? 32'h0 : rom_rdata;
        wr_entry.pre_addr  = infl_q.pre_addr;
        wr_entry.pre_taken = infl_q.pre_taken;
        wr_entry.adel      = infl_q.adel;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            infl_v_q <= 1'b0;
            infl_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            infl_v_q <= infl_v_d;
            infl_q   <= infl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    assign id_valid = (count != '0);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        id_pc        = 32'h0;
        id_inst      = 32'h0;
        id_pre_addr  = 32'h0;
        id_pre_taken = 1'b0;
        id_adel      = 1'b0;
        if (id_valid) begin
            id_pc        = head.pc;
            id_inst      = head.inst;
            id_pre_addr  = head.pre_addr;
            id_pre_taken = head.pre_taken;
            id_adel      = head.adel;
        end
    end

endmodule
